bp_ptw_sv39: RTL and testbench

//  Hardware page-table walker answering TLB misses. Accepts a miss (vtag) from the D/I TLB, walks
//  the 3-level Sv39 table through a single-outstanding memory port, and returns a one-cycle fill
//  (vtag + leaf entry) that drives the TLB write port (v_i=w_i=1), or a page-fault pulse.

---
 rtl/bp_common_pkg.sv | 45 ++++
 rtl/bp_ptw_pte_decode.sv | 65 ++++++
 rtl/bp_ptw_sv39.sv | 136 +++++++++++++
 tb/tb_bp_ptw_sv39.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_common_pkg.sv
// Shared Sv39 page-table-walker types and constants.
//   bp_sv39_pte_s        : full 64-bit Sv39 PTE layout
//   bp_pte_entry_leaf_s  : leaf entry written to the TLB {ptag, d, a, u, x, w, r}
//   bp_ptw_state_e       : walker FSM states
package bp_common_pkg;

  localparam int unsigned sv39_levels_gp        = 3;
  localparam int unsigned sv39_vpn_seg_width_gp = 9;
  localparam int unsigned sv39_pte_bytes_gp     = 8;
  localparam int unsigned sv39_ptag_width_gp    = 28;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d;
    logic        a;
    logic        g;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
    logic        v;
  } bp_sv39_pte_s;

  typedef struct packed {
    logic [sv39_ptag_width_gp-1:0] ptag;
    logic                          d;
    logic                          a;
    logic                          u;
    logic                          x;
    logic                          w;
    logic                          r;
  } bp_pte_entry_leaf_s;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWait,
    StFill,
    StFault,
    StDrain
  } bp_ptw_state_e;

endpackage

// File: rtl/bp_ptw_pte_decode.sv
// Combinational Sv39 PTE decode for one walk step.
//   pte_i         : PTE returned by memory
//   level_i       : current walk level (2 = root)
//   vtag_low_i    : low 18 vtag bits, spliced into superpage ptags
//   leaf_o        : PTE is a leaf (R|X)
//   fault_o       : PTE raises a page fault at this level
//   next_ppn_o    : next-level table PPN for pointer PTEs
//   entry_o       : leaf entry for the TLB fill
module bp_ptw_pte_decode
  import bp_common_pkg::*;
(
  input  logic [63:0]                   pte_i,
  input  logic [1:0]                    level_i,
  input  logic [17:0]                   vtag_low_i,
  output logic                          leaf_o,
  output logic                          fault_o,
  output logic [sv39_ptag_width_gp-1:0] next_ppn_o,
  output bp_pte_entry_leaf_s            entry_o
);

  bp_sv39_pte_s                  pte;
  logic [sv39_ptag_width_gp-1:0] ptag;
  logic                          leaf;
  logic                          misaligned;
  logic                          unused;

  assign pte    = pte_i;
  assign unused = ^{pte.reserved, pte.rsw, pte.g};

  always_comb begin
    leaf       = pte.r | pte.x;
    ptag       = pte.ppn[sv39_ptag_width_gp-1:0];
    misaligned = 1'b0;
    // Superpages take their low PPN bits from the virtual address.
    case (level_i)
      2'd2: begin
        misaligned  = |pte.ppn[17:0];
        ptag[17:0]  = vtag_low_i[17:0];
      end
      2'd1: begin
        misaligned  = |pte.ppn[8:0];
        ptag[8:0]   = vtag_low_i[8:0];
      end
      default: ;
    endcase

    fault_o = ~pte.v
            | (~pte.r & pte.w)
            | (|pte.ppn[43:sv39_ptag_width_gp])
            | (leaf & ~pte.a)
            | (~leaf & (level_i == 2'd0))
            | (leaf & misaligned);

    leaf_o       = leaf;
    next_ppn_o   = pte.ppn[sv39_ptag_width_gp-1:0];
    entry_o.ptag = ptag;
    entry_o.d    = pte.d;
    entry_o.a    = pte.a;
    entry_o.u    = pte.u;
    entry_o.x    = pte.x;
    entry_o.w    = pte.w;
    entry_o.r    = pte.r;
  end

endmodule

// File: rtl/bp_ptw_sv39.sv
// Sv39 hardware page-table walker.
//   Accepts a TLB miss (miss_v_i/miss_vtag_i) when idle, walks up to three levels through a
//   single-outstanding memory port (mem_req_*/mem_resp_*), then emits either a one-cycle TLB fill
//   (tlb_w_*) or a one-cycle page fault (fault_*). busy_o is high in every non-idle state.
//   flush_i aborts the walk; an in-flight memory response is drained and discarded.
module bp_ptw_sv39
  import bp_common_pkg::*;
#(
  parameter int unsigned  vtag_width_p   = 27,
  parameter int unsigned  paddr_width_p  = 40,
  parameter int unsigned  pte_width_p    = 64,
  localparam int unsigned ptag_width_lp  = paddr_width_p - 12,
  localparam int unsigned entry_width_lp = ptag_width_lp + 6
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [ptag_width_lp-1:0]  base_ppn_i,
  input  logic                      miss_v_i,
  input  logic [vtag_width_p-1:0]   miss_vtag_i,
  output logic                      busy_o,
  output logic                      mem_req_v_o,
  output logic [paddr_width_p-1:0]  mem_req_addr_o,
  input  logic                      mem_req_ready_i,
  input  logic                      mem_resp_v_i,
  input  logic [pte_width_p-1:0]    mem_resp_data_i,
  output logic                      tlb_w_v_o,
  output logic [vtag_width_p-1:0]   tlb_w_vtag_o,
  output logic [entry_width_lp-1:0] tlb_w_entry_o,
  output logic                      fault_v_o,
  output logic [vtag_width_p-1:0]   fault_vtag_o
);

  bp_ptw_state_e               state_q, state_d;
  logic [vtag_width_p-1:0]     vtag_q, vtag_d;
  logic [ptag_width_lp-1:0]    ppn_q, ppn_d;
  logic [1:0]                  level_q, level_d;
  bp_pte_entry_leaf_s          entry_q, entry_d;

  logic                        dec_leaf;
  logic                        dec_fault;
  logic [ptag_width_lp-1:0]    dec_next_ppn;
  bp_pte_entry_leaf_s          dec_entry;
  logic [8:0]                  vpn_seg;

  bp_ptw_pte_decode u_decode (
    .pte_i      (mem_resp_data_i),
    .level_i    (level_q),
    .vtag_low_i (vtag_q[17:0]),
    .leaf_o     (dec_leaf),
    .fault_o    (dec_fault),
    .next_ppn_o (dec_next_ppn),
    .entry_o    (dec_entry)
  );

  always_comb begin
    case (level_q)
      2'd2:    vpn_seg = vtag_q[26:18];
      2'd1:    vpn_seg = vtag_q[17:9];
      default: vpn_seg = vtag_q[8:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    vtag_d  = vtag_q;
    ppn_d   = ppn_q;
    level_d = level_q;
    entry_d = entry_q;
    unique case (state_q)
      StIdle: begin
        if (miss_v_i && !flush_i) begin
          vtag_d  = miss_vtag_i;
          ppn_d   = base_ppn_i;
          level_d = 2'd2;
          state_d = StSend;
        end
      end
      StSend: begin
        // A request accepted in the flush cycle still owes us a response.
        if (flush_i)              state_d = mem_req_ready_i ? StDrain : StIdle;
        else if (mem_req_ready_i) state_d = StWait;
      end
      StWait: begin
        if (mem_resp_v_i) begin
          if (flush_i) begin
            state_d = StIdle;
          end else if (dec_fault) begin
            state_d = StFault;
          end else if (dec_leaf) begin
            entry_d = dec_entry;
            state_d = StFill;
          end else begin
            ppn_d   = dec_next_ppn;
            level_d = level_q - 2'd1;
            state_d = StSend;
          end
        end else if (flush_i) begin
          state_d = StDrain;
        end
      end
      StFill, StFault: state_d = StIdle;
      StDrain: begin
        if (mem_resp_v_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      vtag_q  <= '0;
      ppn_q   <= '0;
      level_q <= '0;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      vtag_q  <= vtag_d;
      ppn_q   <= ppn_d;
      level_q <= level_d;
      entry_q <= entry_d;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign mem_req_v_o    = (state_q == StSend);
  assign mem_req_addr_o = {ppn_q, vpn_seg, 3'b000};
  // A flush landing on the result cycle cancels the result.
  assign tlb_w_v_o      = (state_q == StFill) & ~flush_i;
  assign tlb_w_vtag_o   = vtag_q;
  assign tlb_w_entry_o  = entry_q;
  assign fault_v_o      = (state_q == StFault) & ~flush_i;
  assign fault_vtag_o   = vtag_q;

endmodule

// File: tb/tb_bp_ptw_sv39.sv
module tb_bp_ptw_sv39;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, miss_v, mem_req_ready, mem_resp_v;
  logic [27:0] base_ppn;
  logic [26:0] miss_vtag;
  logic [63:0] mem_resp_data;
  logic        busy, mem_req_v, tlb_w_v, fault_v;
  logic [39:0] mem_req_addr;
  logic [26:0] tlb_w_vtag, fault_vtag;
  logic [33:0] tlb_w_entry;

  bp_ptw_sv39 dut (
    .clk_i           (clk),
    .reset_i         (reset),
    .flush_i         (flush),
    .base_ppn_i      (base_ppn),
    .miss_v_i        (miss_v),
    .miss_vtag_i     (miss_vtag),
    .busy_o          (busy),
    .mem_req_v_o     (mem_req_v),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_ready_i (mem_req_ready),
    .mem_resp_v_i    (mem_resp_v),
    .mem_resp_data_i (mem_resp_data),
    .tlb_w_v_o       (tlb_w_v),
    .tlb_w_vtag_o    (tlb_w_vtag),
    .tlb_w_entry_o   (tlb_w_entry),
    .fault_v_o       (fault_v),
    .fault_vtag_o    (fault_vtag)
  );

  typedef struct {
    logic        is_fault;
    logic [26:0] vtag;
    logic [33:0] entry;
  } exp_t;

  typedef struct {
    string           name;
    logic [26:0]     vtag;
    logic [27:0]     base;
    logic            is_fault;
    logic [33:0]     entry;
    int              nreq;
    logic [2:0][39:0] addr;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [39:0] req_log[$];
  logic [63:0] mem [logic [39:0]];
  int          resp_lat = 1;
  int          resp_cnt = 0;
  logic [39:0] resp_addr;
  vec_t        vecs[9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] pte(input logic [43:0] ppn, input logic [7:0] flags);
    return {10'd0, ppn, 2'b00, flags};
  endfunction

  function automatic vec_t mk(input string n, input logic [26:0] vt, input logic [27:0] b,
                              input logic f, input logic [33:0] ent, input int nr,
                              input logic [39:0] a0, input logic [39:0] a1,
                              input logic [39:0] a2);
    vec_t v;
    v.name = n; v.vtag = vt; v.base = b; v.is_fault = f; v.entry = ent; v.nreq = nr;
    v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    return v;
  endfunction

  // Memory responder: one response resp_lat cycles after each accepted request.
  initial begin
    mem_resp_v    = 1'b0;
    mem_resp_data = '0;
    forever begin
      @(negedge clk);
      mem_resp_v = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_resp_v    = 1'b1;
          mem_resp_data = mem.exists(resp_addr) ? mem[resp_addr] : 64'd0;
        end
      end
      if (mem_req_v && mem_req_ready) begin
        req_log.push_back(mem_req_addr);
        resp_addr = mem_req_addr;
        resp_cnt  = resp_lat;
      end
    end
  end

  // Output monitor: every pulse pops one expected result from the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (tlb_w_v && fault_v) check("pulse_overlap", {tlb_w_v, fault_v}, 2'b00);
      if (tlb_w_v || fault_v) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {tlb_w_v, fault_v}, 2'b00);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", fault_v, mon_e.is_fault);
          if (mon_e.is_fault) begin
            check("fault_vtag", fault_vtag, mon_e.vtag);
          end else begin
            check("fill_vtag", tlb_w_vtag, mon_e.vtag);
            check("fill_entry", tlb_w_entry, mon_e.entry);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_miss(input logic [26:0] vt, input logic [27:0] bp);
    miss_v = 1'b1; miss_vtag = vt; base_ppn = bp;
    tick();
    miss_v = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_reqs(input int n);
    int k = 0;
    while (req_log.size() < n && k < 100) begin
      tick();
      k++;
    end
    check("req_wait", req_log.size(), n);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    req_log.delete();
    e.is_fault = v.is_fault; e.vtag = v.vtag; e.entry = v.entry;
    exp_q.push_back(e);
    start_miss(v.vtag, v.base);
    wait_idle(v.name);
    check({v.name, "_nreq"}, req_log.size(), v.nreq);
    for (int i = 0; i < v.nreq && i < req_log.size(); i++)
      check({v.name, "_addr"}, req_log[i], v.addr[i]);
    check({v.name, "_pulse_seen"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; miss_v = 1'b0; miss_vtag = '0; base_ppn = '0;
    mem_req_ready = 1'b1;

    mem[40'h100008] = pte(44'h200, 8'h01);
    mem[40'h200008] = pte(44'h300, 8'h01);
    mem[40'h300008] = pte(44'h8765, 8'hCF);
    mem[40'h110008] = pte(44'h40000, 8'h53);
    mem[40'h170008] = pte(44'h171, 8'h01);
    mem[40'h171008] = pte(44'h1200, 8'hCF);
    mem[40'h120008] = pte(44'h121, 8'h01);
    mem[40'h130008] = pte(44'h0, 8'h45);
    mem[40'h140008] = pte(44'h141, 8'h01);
    mem[40'h141008] = pte(44'h123, 8'hCF);
    mem[40'h150008] = pte(44'h151, 8'h01);
    mem[40'h151008] = pte(44'h152, 8'h01);
    mem[40'h152008] = pte(44'h4444, 8'h03);
    mem[40'h160008] = pte(44'h10004_0000, 8'hCF);
    mem[40'h180008] = pte(44'h181, 8'h01);
    mem[40'h181008] = pte(44'h182, 8'h01);
    mem[40'h182008] = pte(44'h183, 8'h01);

    vecs[0] = mk("walk_4k", 27'h0040201, 28'h100, 1'b0, {28'h8765, 6'b110111}, 3,
                 40'h100008, 40'h200008, 40'h300008);
    vecs[1] = mk("super_1g", 27'h007FFFF, 28'h110, 1'b0, {28'h7FFFF, 6'b011001}, 1,
                 40'h110008, 40'h0, 40'h0);
    vecs[2] = mk("super_2m", 27'h0040201, 28'h170, 1'b0, {28'h1201, 6'b110111}, 2,
                 40'h170008, 40'h171008, 40'h0);
    vecs[3] = mk("flt_inval", 27'h0040201, 28'h120, 1'b1, 34'h0, 2,
                 40'h120008, 40'h121008, 40'h0);
    vecs[4] = mk("flt_wnr", 27'h007FFFF, 28'h130, 1'b1, 34'h0, 1,
                 40'h130008, 40'h0, 40'h0);
    vecs[5] = mk("flt_misalign", 27'h0040201, 28'h140, 1'b1, 34'h0, 2,
                 40'h140008, 40'h141008, 40'h0);
    vecs[6] = mk("flt_noaccess", 27'h0040201, 28'h150, 1'b1, 34'h0, 3,
                 40'h150008, 40'h151008, 40'h152008);
    vecs[7] = mk("flt_ppn_hi", 27'h007FFFF, 28'h160, 1'b1, 34'h0, 1,
                 40'h160008, 40'h0, 40'h0);
    vecs[8] = mk("flt_ptr_l0", 27'h0040201, 28'h180, 1'b1, 34'h0, 3,
                 40'h180008, 40'h181008, 40'h182008);

    repeat (3) tick();
    reset = 1'b0;
    check("reset_ctrl", {busy, mem_req_v, tlb_w_v, fault_v}, 4'b0000);
    check("reset_entry", tlb_w_entry, 34'h0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Flush while waiting: the late response must be dropped without a fill.
    resp_lat = 6; req_log.delete();
    start_miss(27'h0040201, 28'h100);
    wait_reqs(1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("drain_busy", busy, 1'b1);
    check("drain_no_req", mem_req_v, 1'b0);
    wait_idle("drain");
    check("drain_req_count", req_log.size(), 1);
    resp_lat = 1;
    run_vec(vecs[0]);

    // Back-pressure: request held stable, miss while busy ignored.
    begin
      exp_t e;
      e.is_fault = 1'b0; e.vtag = 27'h0040201; e.entry = {28'h8765, 6'b110111};
      exp_q.push_back(e);
    end
    mem_req_ready = 1'b0; req_log.delete();
    start_miss(27'h0040201, 28'h100);
    for (int i = 0; i < 10; i++) begin
      miss_v = (i == 3); miss_vtag = 27'h007FFFF; base_ppn = 28'h110;
      check("stall_req_v", mem_req_v, 1'b1);
      check("stall_addr", mem_req_addr, 40'h100008);
      tick();
    end
    miss_v = 1'b0; mem_req_ready = 1'b1;
    wait_idle("stall");
    repeat (3) tick();
    check("stall_no_rewalk", busy, 1'b0);
    check("stall_req_count", req_log.size(), 3);
    check("stall_pulse_seen", exp_q.size(), 0);
    exp_q.delete();

    // Reset mid-walk, stray response afterwards.
    resp_lat = 4; req_log.delete();
    start_miss(27'h0040201, 28'h100);
    wait_reqs(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_ctrl", {busy, mem_req_v, tlb_w_v, fault_v}, 4'b0000);
    check("midrst_data", {tlb_w_vtag, tlb_w_entry, fault_vtag}, 88'h0);
    check("midrst_addr", mem_req_addr, 40'h0);
    repeat (8) tick();
    check("midrst_stray_busy", busy, 1'b0);
    resp_lat = 1;
    run_vec(vecs[1]);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
